// File: rtl/axis_pkg.sv
// axis_pkg: shared state encoding, default widths and strobe helper for the AXIS packet generator.
package axis_pkg;
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;
    function automatic logic [127:0] STRB_ALL_ONES(input int bytes);
        return (128'd1 << bytes) - 128'd1;
    endfunction
endpackage

// File: rtl/axis_packet_gen.sv
// axis_packet_gen: AXI-Stream source emitting base, base+step, ... packets on a start pulse.
// Optional trailing checksum beat enabled by defining AXIS_PKT_CHECKSUM_EN.
module axis_packet_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [DATA_WIDTH-1:0]   base,
    input  logic [DATA_WIDTH-1:0]   step,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic                    m00_axis_tlast
);
    localparam int STRB_W = DATA_WIDTH / 8;
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_data, r_step;
    logic [LEN_WIDTH-1:0]  r_len, r_cnt;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_valid, r_last, r_busy, r_done;
    logic                  w_hs, w_accept, w_last_data, w_final;
`ifdef AXIS_PKT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif
    always_comb begin
        w_hs        = r_valid && m00_axis_tready;
        w_accept    = r_state == IDLE && start && pkt_len != '0;
        w_last_data = r_cnt == r_len - LEN_WIDTH'(1);
`ifdef AXIS_PKT_CHECKSUM_EN
        w_final     = w_hs && r_state == CSUM;
        w_next      = w_accept ? SEND
                    : (w_hs && r_state == SEND && w_last_data) ? CSUM
                    : w_final ? IDLE : r_state;
`else
        w_final     = w_hs && r_state == SEND && w_last_data;
        w_next      = w_accept ? SEND : w_final ? IDLE : r_state;
`endif
    end
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) r_state <= IDLE;
        else                   r_state <= w_next;
    end
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            r_data  <= '0;
            r_step  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef AXIS_PKT_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_done <= w_final;
            if (w_accept) begin
                r_data  <= base;
                r_step  <= step;
                r_len   <= pkt_len;
                r_cnt   <= '0;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
`ifdef AXIS_PKT_CHECKSUM_EN
                r_last  <= 1'b0;
                r_sum   <= '0;
`else
                r_last  <= pkt_len == LEN_WIDTH'(1);
`endif
            end else if (w_hs && r_state == SEND) begin
                r_cnt  <= r_cnt + LEN_WIDTH'(1);
                r_data <= r_data + r_step;
`ifdef AXIS_PKT_CHECKSUM_EN
                r_sum  <= r_sum + r_data;
                if (w_last_data) begin
                    r_data <= r_sum + r_data;
                    r_last <= 1'b1;
                end
`else
                r_last <= r_cnt + LEN_WIDTH'(2) == r_len;
`endif
            end
            if (w_final) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end
    assign busy            = r_busy;
    assign done            = r_done;
    assign pkt_count       = r_count;
    assign m00_axis_tdata  = r_data;
    assign m00_axis_tstrb  = STRB_W'(STRB_ALL_ONES(STRB_W));
    assign m00_axis_tvalid = r_valid;
    assign m00_axis_tlast  = r_last;
endmodule
